cv32e40p_obi_rr_arbiter: RTL

- Parametrised N-master to 1-slave OBI arbiter placed between cv32e40p_top ports (instr, data, and later debug or DMA masters) and impl_mm_ram in multi-master subsystems.
- Uses round-robin arbitration with a request lock while the slave stalls.
- Tracks up to MAX_OUTSTANDING in-order transactions and routes each response back to the master that issued it.

---
 rtl/cv32e40p_obi_pkg.sv | 19 +
 rtl/cv32e40p_obi_id_fifo.sv | 55 +++++
 rtl/cv32e40p_obi_rr_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and helpers for the multi-master OBI interconnect.
package cv32e40p_obi_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;

    // Master-ID width; never collapses to zero bits, even for a single master.
    function automatic int id_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

    typedef struct packed {
        logic [OBI_ADDR_W-1:0]   addr;
        logic                    we;
        logic [OBI_DATA_W/8-1:0] be;
        logic [OBI_DATA_W-1:0]   wdata;
    } obi_req_t;

endpackage

// File: rtl/cv32e40p_obi_id_fifo.sv
// In-order FIFO of master IDs for transactions whose response is still pending.
module cv32e40p_obi_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/cv32e40p_obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter: round-robin selection, address lock while
// the slave stalls, and in-order routing of responses to the issuing master.
module cv32e40p_obi_rr_arbiter
    import cv32e40p_obi_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NUM_MASTERS-1:0]                     m_req_i,
    output logic [NUM_MASTERS-1:0]                     m_gnt_o,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NUM_MASTERS-1:0]                     m_we_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]   m_be_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]     m_wdata_i,
    output logic [NUM_MASTERS-1:0]                     m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                      m_rdata_o,
    output logic                                       s_req_o,
    input  logic                                       s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                      s_addr_o,
    output logic                                       s_we_o,
    output logic [DATA_WIDTH/8-1:0]                    s_be_o,
    output logic [DATA_WIDTH-1:0]                      s_wdata_o,
    input  logic                                       s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                      s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
    output logic                                       err_o
);

    localparam int IDW = id_width(NUM_MASTERS);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] locked_id_q, locked_id_d;
    logic           lock_q, lock_d;
    logic           err_q, err_d;
    logic [IDW-1:0] scan_id, winner, head_id;
    logic           hs, pop, full, empty;

    always_comb begin : p_scan
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        scan_id = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
            if (!found && m_req_i[idx]) begin
                found   = 1'b1;
                scan_id = IDW'(idx);
            end
        end
    end

    // A stalled request keeps its master so the slave sees stable attributes.
    assign winner = lock_q ? locked_id_q : scan_id;

    assign s_req_o   = (|m_req_i) & ~full;
    assign s_addr_o  = m_addr_i[winner];
    assign s_we_o    = m_we_i[winner];
    assign s_be_o    = m_be_i[winner];
    assign s_wdata_o = m_wdata_i[winner];

    assign hs        = s_req_o & s_gnt_i;
    assign pop       = s_rvalid_i & ~empty;
    assign m_rdata_o = s_rdata_i;
    assign err_o     = err_q;

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (hs)  m_gnt_o[winner]     = 1'b1;
        if (pop) m_rvalid_o[head_id] = 1'b1;
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        err_d       = err_q | (s_rvalid_i & empty);
        if (hs) begin
            rr_ptr_d = (winner == IDW'(NUM_MASTERS-1)) ? '0 : winner + IDW'(1);
            lock_d   = 1'b0;
        end else if (s_req_o) begin
            lock_d      = 1'b1;
            locked_id_d = winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            err_q       <= err_d;
        end
    end

    cv32e40p_obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

endmodule
